// File: rtl/coord_tracker.sv
// Detector coordinate tracker: validates per-frame samples, smooths them with a shift-based EMA,
// derives motion deltas and lock/lost state, and queues results in a small FWFT output FIFO.
module coord_tracker #(
    parameter int unsigned X_MAX        = 1279,
    parameter int unsigned Y_MAX        = 719,
    parameter int unsigned SMOOTH_SHIFT = 2,
    parameter int unsigned LOST_FRAMES  = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] COORDINATE,
    input  logic        READY,
    output logic [31:0] OUT_COORD,
    output logic [31:0] OUT_DELTA,
    output logic [1:0]  OUT_FLAGS,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        TRACKING,
    output logic [15:0] DROP_COUNT
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned MW = $clog2(LOST_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, LOST} state_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] dx;
        logic [15:0] dy;
        logic [1:0]  flags;
    } entry_t;

    state_t        state, state_next;
    logic [15:0]   smooth_x, smooth_y, sx_next, sy_next;
    logic [15:0]   step_x, step_y;
    logic [MW-1:0] miss, miss_next;
    entry_t        ent, ent_next;
    logic          push, push_next;
    logic [15:0]   sample_x, sample_y;
    logic          sample_ok;

    // Arithmetic shift rounds toward -inf, which keeps smooth inside the sample range.
    function automatic logic [15:0] ema_step(input logic [15:0] s, input logic [15:0] m);
        logic signed [16:0] diff;
        diff = signed'({1'b0, s}) - signed'({1'b0, m});
        return 16'(diff >>> SMOOTH_SHIFT);
    endfunction

    assign sample_x  = COORDINATE[31:16];
    assign sample_y  = COORDINATE[15:0];
    assign sample_ok = (sample_x <= 16'(X_MAX)) && (sample_y <= 16'(Y_MAX));
    assign step_x    = ema_step(sample_x, smooth_x);
    assign step_y    = ema_step(sample_y, smooth_y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            smooth_x <= '0;
            smooth_y <= '0;
            miss     <= '0;
            ent      <= '0;
            push     <= 1'b0;
        end else begin
            state    <= state_next;
            smooth_x <= sx_next;
            smooth_y <= sy_next;
            miss     <= miss_next;
            ent      <= ent_next;
            push     <= push_next;
        end
    end

    always_comb begin
        state_next = state;
        sx_next    = smooth_x;
        sy_next    = smooth_y;
        miss_next  = miss;
        ent_next   = ent;
        push_next  = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            miss_next  = '0;
        end else if (READY) begin
            case (state)
                IDLE, LOST: begin
                    if (sample_ok) begin
                        sx_next    = sample_x;
                        sy_next    = sample_y;
                        miss_next  = '0;
                        ent_next   = '{x: sample_x, y: sample_y, dx: 16'h0, dy: 16'h0, flags: 2'b01};
                        push_next  = 1'b1;
                        state_next = TRACK;
                    end
                end
                TRACK: begin
                    if (sample_ok) begin
                        sx_next   = smooth_x + step_x;
                        sy_next   = smooth_y + step_y;
                        miss_next = '0;
                        ent_next  = '{x: sx_next, y: sy_next, dx: step_x, dy: step_y, flags: 2'b00};
                        push_next = 1'b1;
                    end else if (miss == MW'(LOST_FRAMES - 1)) begin
                        miss_next  = '0;
                        ent_next   = '{x: smooth_x, y: smooth_y, dx: 16'h0, dy: 16'h0, flags: 2'b10};
                        push_next  = 1'b1;
                        state_next = LOST;
                    end else begin
                        miss_next = miss + MW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output FIFO: first-word fall-through, drop-on-full unless a pop frees the slot.
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          full, pop, wr_en;
    entry_t        head;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign pop   = OUT_VALID && OUT_READY;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            DROP_COUNT <= '0;
        end else if (!enable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count <= count + CW'(1);
            else if (!wr_en && pop) count <= count - CW'(1);
            if (push && full && !pop && (DROP_COUNT != 16'hFFFF))
                DROP_COUNT <= DROP_COUNT + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (enable && wr_en) mem[wr_ptr] <= ent;
    end

    assign head      = mem[rd_ptr];
    assign OUT_VALID = (count != '0);
    assign OUT_COORD = OUT_VALID ? {head.x, head.y} : 32'h0;
    assign OUT_DELTA = OUT_VALID ? {head.dx, head.dy} : 32'h0;
    assign OUT_FLAGS = OUT_VALID ? head.flags : 2'b00;
    assign TRACKING  = (state == TRACK);

endmodule
